// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: binary value -> BCD (sequential double-dabble, one bit per
// clock) -> time-multiplexed common-anode 7-segment display.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (blank leading zero digits).

// Per-digit double-dabble correction: add 3 when the digit is 5 or more.
module seg_dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module seg_display_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  // Accumulator has one spare digit beyond what WIDTH bits can ever need.
  localparam int NACC = (WIDTH + 2) / 3 + 1;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int RW   = $clog2(REFRESH_DIV);
  localparam int SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]         sh;
  logic [CW-1:0]            bit_cnt;
  logic [NACC-1:0][3:0]     acc, acc_sh;
  logic [4*NACC-1:0]        acc_adj;
  logic [DIGITS-1:0][3:0]   dig, dig_nxt, dig_conv;
  logic                     ovf_conv, ovf_nxt, last_shift;
  logic [RW-1:0]            ref_cnt;
  logic [SW-1:0]            scan, scan_nxt;
  logic [DIGITS-1:0]        blank;

  // Array of per-digit correction lanes.
  for (genvar i = 0; i < NACC; i++) begin : g_dab
    seg_dabble_digit u_dab (.d(acc[i]), .q(acc_adj[4*i +: 4]));
  end

  // Corrected accumulator shifted left, pulling in the next value bit.
  assign acc_sh = {acc_adj[4*NACC-2:0], sh[WIDTH-1]};

  // Displayed digits; digit positions above the accumulator read as zero.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i < NACC) begin : g_src
      assign dig_conv[i] = acc_sh[i];
    end else begin : g_zero
      assign dig_conv[i] = 4'd0;
    end
  end

  // Overflow: any nonzero accumulator digit above the displayed ones. The
  // correction carry out of the top digit is folded in for completeness; it
  // cannot occur with the spare digit in place.
  always_comb begin
    ovf_conv = acc_adj[4*NACC-1];
    for (int i = DIGITS; i < NACC; i++)
      ovf_conv = ovf_conv | (acc_sh[i] != 4'd0);
  end

  assign last_shift = (state == SHIFT) && (bit_cnt == CW'(1));
  assign dig_nxt    = last_shift ? dig_conv : dig;
  assign ovf_nxt    = last_shift ? ovf_conv : overflow;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // Next-state logic: load only in IDLE, WIDTH shift cycles, one DONE cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and conversion datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      acc     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && load) begin
        sh      <= value;
        bit_cnt <= CW'(WIDTH);
        acc     <= '0;
      end else if (state == SHIFT) begin
        sh      <= sh << 1;
        bit_cnt <= bit_cnt - CW'(1);
        acc     <= acc_sh;
      end
    end
  end

  // Display digit and overflow registers, loaded on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig      <= '0;
      overflow <= 1'b0;
    end else begin
      dig      <= dig_nxt;
      overflow <= ovf_nxt;
    end
  end

  assign scan_nxt = (ref_cnt == RW'(REFRESH_DIV - 1)) ?
                    ((scan == SW'(DIGITS - 1)) ? '0 : scan + SW'(1)) : scan;

  // Free-running refresh counter and scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      scan    <= '0;
    end else begin
      ref_cnt <= (ref_cnt == RW'(REFRESH_DIV - 1)) ? '0 : ref_cnt + RW'(1);
      scan    <= scan_nxt;
    end
  end

  // Leading-zero blanking: a digit is blank if it and all digits above are 0.
  always_comb begin
    blank = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin : b_lead
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        lead     = lead & (dig_nxt[i] == 4'd0);
        blank[i] = lead;
      end
    end
`endif
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = ~7'b0111111;
      4'd1:    enc = ~7'b0000110;
      4'd2:    enc = ~7'b1011011;
      4'd3:    enc = ~7'b1001111;
      4'd4:    enc = ~7'b1100110;
      4'd5:    enc = ~7'b1101101;
      4'd6:    enc = ~7'b1111101;
      4'd7:    enc = ~7'b0000111;
      4'd8:    enc = ~7'b1111111;
      4'd9:    enc = ~7'b1101111;
      default: enc = 7'h7F;
    endcase
  endfunction

  // Segment and anode registers, driven from next-state values so both move
  // together and a new result is visible in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      an <= ~(DIGITS'(1) << scan_nxt);
      if (ovf_nxt)              seg <= ~7'b1000000;
      else if (blank[scan_nxt]) seg <= 7'h7F;
      else                      seg <= enc(dig_nxt[scan_nxt]);
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: a 3-digit and a 2-digit instance,
// expected conversions queued at load time and checked when done pulses.
module tb_seg_display_ctrl;
  localparam int W = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] value = '0;
  logic load_a = 1'b0, load_b = 1'b0;
  logic busy_a, done_a, overflow_a, busy_b, done_b, overflow_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] an_a;
  logic [1:0] an_b;

  int tests = 0, fails = 0;
  int cyc = 0, free_a = 0, free_b = 0;

  typedef struct { int unsigned v; int due; } exp_t;
  exp_t q_a[$], q_b[$];

  localparam logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011,
    7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111,
    7'b1101111};

  seg_display_ctrl #(.WIDTH(W), .DIGITS(3), .REFRESH_DIV(R)) u_a (
    .clk(clk), .rst(rst), .value(value), .load(load_a), .busy(busy_a),
    .done(done_a), .overflow(overflow_a), .seg(seg_a), .an(an_a));

  seg_display_ctrl #(.WIDTH(W), .DIGITS(2), .REFRESH_DIV(R)) u_b (
    .clk(clk), .rst(rst), .value(value), .load(load_b), .busy(busy_b),
    .done(done_b), .overflow(overflow_b), .seg(seg_b), .an(an_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] exp_seg(input int unsigned v, input int nd, input int idx);
    int unsigned p = 1;
    int unsigned lim = 1;
    int d;
    for (int i = 0; i < idx; i++) p = p * 10;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v >= lim) return ~7'b1000000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < p) return 7'h7F;
`endif
    d = int'((v / p) % 10);
    return ~PAT[d];
  endfunction

  function automatic int scan_idx(input logic [2:0] anv, input int nd);
    int idx = -1;
    int n = 0;
    for (int i = 0; i < nd; i++)
      if (anv[i] === 1'b0) begin idx = i; n++; end
    return (n == 1) ? idx : -1;
  endfunction

  // Scoreboard for the 3-digit instance.
  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1) begin
      tests++;
      if (q_a.size() == 0) begin
        fails++; $display("FAIL done_a_spurious: done=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q_a.pop_front();
        if (cyc != e.due) begin
          fails++; $display("FAIL done_a_latency v=%0d: cycle %0d, required %0d", e.v, cyc, e.due);
        end
        tests++;
        if (overflow_a !== (e.v > 999)) begin
          fails++; $display("FAIL ovf_a v=%0d: %b, required %b", e.v, overflow_a, e.v > 999);
        end
        tests++;
        if (seg_a !== exp_seg(e.v, 3, scan_idx(an_a, 3))) begin
          fails++; $display("FAIL seg_at_done_a v=%0d: %h, required %h", e.v, seg_a,
                            exp_seg(e.v, 3, scan_idx(an_a, 3)));
        end
      end
    end else if (q_a.size() > 0 && cyc > q_a[0].due) begin
      tests++; fails++;
      $display("FAIL done_a_missing v=%0d: none by cycle %0d, required at %0d", q_a[0].v, cyc, q_a[0].due);
      void'(q_a.pop_front());
    end
  end

  // Scoreboard for the 2-digit instance.
  always @(negedge clk) begin
    exp_t e;
    if (done_b === 1'b1) begin
      tests++;
      if (q_b.size() == 0) begin
        fails++; $display("FAIL done_b_spurious: done=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q_b.pop_front();
        if (cyc != e.due) begin
          fails++; $display("FAIL done_b_latency v=%0d: cycle %0d, required %0d", e.v, cyc, e.due);
        end
        tests++;
        if (overflow_b !== (e.v > 99)) begin
          fails++; $display("FAIL ovf_b v=%0d: %b, required %b", e.v, overflow_b, e.v > 99);
        end
      end
    end else if (q_b.size() > 0 && cyc > q_b[0].due) begin
      tests++; fails++;
      $display("FAIL done_b_missing v=%0d: none by cycle %0d, required at %0d", q_b[0].v, cyc, q_b[0].due);
      void'(q_b.pop_front());
    end
  end

  // One-cycle load pulse; queues an expectation only if the model says idle.
  task automatic do_load(input bit b, input int unsigned v);
    @(negedge clk);
    value = W'(v);
    if (b) begin
      load_b = 1'b1;
      if (cyc >= free_b) begin q_b.push_back('{v, cyc + W + 1}); free_b = cyc + W + 2; end
    end else begin
      load_a = 1'b1;
      if (cyc >= free_a) begin q_a.push_back('{v, cyc + W + 1}); free_a = cyc + W + 2; end
    end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Sample a full scan period and check every slot against the model.
  task automatic check_disp(input bit b, input int unsigned v, input string nm);
    int nd, idx;
    logic [2:0] anv;
    logic [6:0] sg, ex;
    nd = b ? 2 : 3;
    for (int n = 0; n < nd * R; n++) begin
      @(negedge clk);
      anv = b ? {1'b1, an_b} : an_a;
      sg  = b ? seg_b : seg_a;
      idx = scan_idx(anv, nd);
      tests++;
      if (idx < 0) begin
        fails++; $display("FAIL %s_an: an=%b, required exactly one low bit", nm, anv);
      end else begin
        ex = exp_seg(v, nd, idx);
        if (sg !== ex) begin
          fails++; $display("FAIL %s_seg[%0d]: seg=%h, required %h", nm, idx, sg, ex);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] ex_an;
    rst = 1'b1; load_a = 1'b0; load_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({seg_a, an_a, busy_a, done_a, overflow_a} !== {7'h7F, 3'b111, 3'b000}) begin
      fails++; $display("FAIL reset_a: seg=%h an=%b busy=%b done=%b ovf=%b, required 7f 111 0 0 0",
                        seg_a, an_a, busy_a, done_a, overflow_a);
    end
    tests++;
    if ({seg_b, an_b, busy_b, done_b, overflow_b} !== {7'h7F, 2'b11, 3'b000}) begin
      fails++; $display("FAIL reset_b: seg=%h an=%b busy=%b done=%b ovf=%b, required 7f 11 0 0 0",
                        seg_b, an_b, busy_b, done_b, overflow_b);
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      ex_an = ~(3'b001 << ((e / 4) % 3));
      tests++;
      if (an_a !== ex_an || seg_a !== exp_seg(0, 3, (e / 4) % 3)) begin
        fails++; $display("FAIL scan_after_reset e=%0d: an=%b seg=%h, required an=%b seg=%h",
                          e, an_a, seg_a, ex_an, exp_seg(0, 3, (e / 4) % 3));
      end
    end
  endtask

  task automatic test_convert();
    do_load(1'b0, 255);
    repeat (W + 2) @(negedge clk);
    check_disp(1'b0, 255, "disp_255");
  endtask

  task automatic test_overflow();
    do_load(1'b1, 100);
    repeat (W + 2) @(negedge clk);
    check_disp(1'b1, 100, "disp_ovf100");
    do_load(1'b1, 99);
    repeat (3) @(negedge clk);
    tests++;
    if (overflow_b !== 1'b1 || busy_b !== 1'b1) begin
      fails++; $display("FAIL ovf_hold: ovf=%b busy=%b, required 1 1", overflow_b, busy_b);
    end
    repeat (W) @(negedge clk);
    tests++;
    if (overflow_b !== 1'b0) begin
      fails++; $display("FAIL ovf_clear: ovf=%b, required 0", overflow_b);
    end
    check_disp(1'b1, 99, "disp_99");
  endtask

  task automatic test_back_to_back();
    int n;
    do_load(1'b0, 123);
    repeat (2) @(negedge clk);
    do_load(1'b0, 45);
    n = 0;
    while (done_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (done_a !== 1'b1) begin
      fails++; $display("FAIL b2b_wait_done: done=%b after %0d cycles, required 1", done_a, n);
    end else begin
      // Load during the DONE cycle must be ignored: nothing is queued.
      value = W'(77);
      load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
    end
    repeat (W + 4) @(negedge clk);
    check_disp(1'b0, 123, "disp_123");
  endtask

  task automatic test_reset_abort();
    do_load(1'b0, 200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q_a.delete(); q_b.delete();
    free_a = 0; free_b = 0;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++; $display("FAIL abort: busy=%b done=%b, required 0 0", busy_a, done_a);
    end
    check_disp(1'b0, 0, "disp_abort");
    do_load(1'b0, 7);
    repeat (W + 2) @(negedge clk);
    check_disp(1'b0, 7, "disp_7");
  endtask

  task automatic test_blank();
    do_load(1'b0, 0);
    repeat (W + 2) @(negedge clk);
    check_disp(1'b0, 0, "disp_0");
    do_load(1'b0, 50);
    repeat (W + 2) @(negedge clk);
    check_disp(1'b0, 50, "disp_50");
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_blank();
    repeat (W + 4) @(negedge clk);
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++; $display("FAIL queue_drain: %0d/%0d pending, required 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Parametrised successor to the 4-bit two-digit 7-segment decoder.
- Takes an unsigned binary value of WIDTH bits and converts it to DIGITS BCD digits with a sequential double-dabble engine (one bit per clock).
- Drives a time-multiplexed common-anode display: shared active-low segment bus plus active-low per-digit enables.
- Sits between the ALU result register and the board's 7-segment digits.

Parameters:
- WIDTH, 8, input value width; legal 4..32.
- DIGITS, 3, displayed digit count; legal 1..8.
- REFRESH_DIV, 50000, clocks per digit scan slot; legal >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- value  in  WIDTH  unsigned value; sampled only on accepted load.
- load  in  1  conversion request; accepted only in IDLE.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse in DONE.
- overflow  out  1  last conversion exceeded 10^DIGITS-1.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  out  DIGITS  active-low digit enables; an[0] is the units digit.

Behaviour:
- Reset (sync, active-high, clk only), values on the edge where rst=1:
  - seg=7'h7F, an=all ones, busy=0, done=0, overflow=0.
  - Digit registers=0, scan index=0, refresh counter=0, FSM=IDLE.
  - rst mid-conversion aborts it: no done pulse, display digits cleared to 0.
- FSM states IDLE, SHIFT, DONE:
  - IDLE, load=1 at edge k: capture value; clear internal BCD accumulator of ceil(WIDTH/3)+1 digits; bit counter=WIDTH; go to SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator digit >=5, then shift left one bit, taking the captured value's MSB. Bit counter decrements; after WIDTH SHIFT cycles go to DONE.
  - DONE, one cycle: done=1, busy=1; return to IDLE.
  - On the edge entering DONE, display digit registers load accumulator digits 0..DIGITS-1.
  - overflow is set to 1 if any accumulator digit >= DIGITS is nonzero, else cleared to 0. It holds until the next completed conversion.
  - Latency: load accepted at edge k, done high in cycle k+WIDTH+1, new display visible from the same cycle.
  - load while busy=1 is ignored; no queueing; value changes while busy have no effect.
  - load asserted in the DONE cycle is ignored; load is accepted again from the first IDLE cycle.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count the scan index advances 0..DIGITS-1 and wraps to 0.
  - an[i]=0 only when scan index = i; exactly one digit is enabled at all times after reset.
  - seg and an are registered, updated together (no ghosting cycle).
- Segment encoding (active-low, shown as ~pattern):
  - 0 ~0111111, 1 ~0000110, 2 ~1011011, 3 ~1001111, 4 ~1100110
  - 5 ~1101101, 6 ~1111101, 7 ~0000111, 8 ~1111111, 9 ~1101111
- Overflow display: when overflow=1, every digit shows dash, ~1000000 (seg g only).

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most-significant nonzero digit show seg=7'h7F while their an is still low; digit 0 is never blanked (value 0 shows "0"). Overflow dashes override blanking.
- Undefined: all DIGITS digits are shown, including leading zeros.

Test Plan (WIDTH=8, DIGITS=3, REFRESH_DIV=4 unless noted):
- rst=1 for 2 cycles -> seg=7'h7F, an=3'b111, busy=0, done=0, overflow=0; then scan shows "000" cycling an 110->101->011 every 4 clocks.
- value=255, load for 1 cycle at edge k -> done pulse only in cycle k+9; digits 2,5,5. an=110 gives seg=~7'b1101101; an=011 gives seg=~7'b1011011.
- DIGITS=2, value=100 -> overflow=1, every slot seg=~7'b1000000. Then value=99 -> overflow=0, digits 9,9 with seg=~7'b1101111.
- load 123, then load 45 three cycles later -> exactly one done pulse; display shows 1,2,3.
- load 200, rst at SHIFT cycle 4 -> no done pulse, busy=0, display 000; next load 7 converts normally.
- With SEG_LEADING_ZERO_BLANK_EN, value=7 -> an=011 and an=101 give seg=7'h7F; an=110 gives seg=~7'b0000111. value=0 shows a single "0".
